// File: rtl/copmem_arbiter.sv
// Read-port arbiter for the split even/odd copper memory: copper fetch vs host readback,
// plus host write sequencing and same-address read-during-write forwarding.
module copmem_arbiter #(
    parameter int unsigned AWIDTH     = 10,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_n_i,
    input  logic              cop_rd_req_i,
    input  logic [AWIDTH-1:0] cop_rd_addr_i,
    output logic              cop_rd_ack_o,
    output logic              cop_rd_valid_o,
    output logic [31:0]       cop_rd_data_o,
    input  logic              host_rd_req_i,
    input  logic [AWIDTH:0]   host_rd_addr_i,
    output logic              host_rd_ack_o,
    output logic              host_rd_valid_o,
    output logic [15:0]       host_rd_data_o,
    input  logic              host_wr_req_i,
    input  logic [AWIDTH:0]   host_wr_addr_i,
    input  logic [15:0]       host_wr_data_i,
    output logic              host_wr_ack_o,
    output logic              even_rd_en_o,
    output logic              odd_rd_en_o,
    output logic [AWIDTH-1:0] mem_rd_addr_o,
    input  logic [15:0]       even_rd_data_i,
    input  logic [15:0]       odd_rd_data_i,
    output logic              even_wr_en_o,
    output logic              odd_wr_en_o,
    output logic [AWIDTH-1:0] mem_wr_addr_o,
    output logic [15:0]       mem_wr_data_o
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_COP,
        OWN_HOST
    } owner_e;

    owner_e            own_q, own_d;
    logic [3:0]        starve_q, starve_d;
    logic [AWIDTH-1:0] rd_addr_q, rd_addr_d;
    logic              host_bank_q, host_bank_d;
    logic              haz_even_q, haz_even_d;
    logic              haz_odd_q, haz_odd_d;
    logic [15:0]       fwd_q, fwd_d;
    logic              cop_valid_q, cop_valid_d;
    logic              host_valid_q, host_valid_d;
    logic [31:0]       cop_data_q, cop_data_d;
    logic [15:0]       host_data_q, host_data_d;

    logic              cop_gnt, host_gnt, starved;
    logic [15:0]       even_eff, odd_eff;

    always_comb begin
        starved  = (starve_q == 4'(STARVE_MAX));
        cop_gnt  = reset_n_i && cop_rd_req_i && !(host_rd_req_i && starved);
        host_gnt = reset_n_i && host_rd_req_i && !cop_gnt;

        cop_rd_ack_o  = cop_gnt;
        host_rd_ack_o = host_gnt;
        even_rd_en_o  = cop_gnt || (host_gnt && !host_rd_addr_i[0]);
        odd_rd_en_o   = cop_gnt || (host_gnt && host_rd_addr_i[0]);
        if (cop_gnt) begin
            mem_rd_addr_o = cop_rd_addr_i;
        end else if (host_gnt) begin
            mem_rd_addr_o = host_rd_addr_i[AWIDTH:1];
        end else begin
            mem_rd_addr_o = rd_addr_q;
        end
        rd_addr_d = mem_rd_addr_o;

        host_wr_ack_o = reset_n_i && host_wr_req_i;
        even_wr_en_o  = host_wr_ack_o && !host_wr_addr_i[0];
        odd_wr_en_o   = host_wr_ack_o && host_wr_addr_i[0];
        mem_wr_addr_o = host_wr_addr_i[AWIDTH:1];
        mem_wr_data_o = host_wr_data_i;

        starve_d = starve_q;
        if (host_gnt) begin
            starve_d = '0;
        end else if (host_rd_req_i && !starved) begin
            starve_d = starve_q + 4'd1;
        end

        if (cop_gnt) begin
            own_d = OWN_COP;
        end else if (host_gnt) begin
            own_d = OWN_HOST;
        end else begin
            own_d = OWN_NONE;
        end
        host_bank_d = host_rd_addr_i[0];

        // Banks return old data on a same-cycle write; remember the write so N+1 sees new data.
        haz_even_d = even_wr_en_o && even_rd_en_o && (mem_wr_addr_o == mem_rd_addr_o);
        haz_odd_d  = odd_wr_en_o && odd_rd_en_o && (mem_wr_addr_o == mem_rd_addr_o);
        fwd_d      = host_wr_data_i;

        even_eff = haz_even_q ? fwd_q : even_rd_data_i;
        odd_eff  = haz_odd_q ? fwd_q : odd_rd_data_i;

        cop_valid_d  = (own_q == OWN_COP);
        host_valid_d = (own_q == OWN_HOST);
        cop_data_d   = cop_valid_d ? {even_eff, odd_eff} : cop_data_q;
        host_data_d  = host_valid_d ? (host_bank_q ? odd_eff : even_eff) : host_data_q;

        cop_rd_valid_o  = cop_valid_q;
        cop_rd_data_o   = cop_data_q;
        host_rd_valid_o = host_valid_q;
        host_rd_data_o  = host_data_q;
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            own_q        <= OWN_NONE;
            starve_q     <= '0;
            rd_addr_q    <= '0;
            host_bank_q  <= 1'b0;
            haz_even_q   <= 1'b0;
            haz_odd_q    <= 1'b0;
            fwd_q        <= '0;
            cop_valid_q  <= 1'b0;
            host_valid_q <= 1'b0;
            cop_data_q   <= '0;
            host_data_q  <= '0;
        end else begin
            own_q        <= own_d;
            starve_q     <= starve_d;
            rd_addr_q    <= rd_addr_d;
            host_bank_q  <= host_bank_d;
            haz_even_q   <= haz_even_d;
            haz_odd_q    <= haz_odd_d;
            fwd_q        <= fwd_d;
            cop_valid_q  <= cop_valid_d;
            host_valid_q <= host_valid_d;
            cop_data_q   <= cop_data_d;
            host_data_q  <= host_data_d;
        end
    end

endmodule

// File: tb/tb_copmem_arbiter.sv
// Self-checking bench for copmem_arbiter: directed vectors, corner sequences, and random
// traffic checked against a shadow-memory model with new-data-on-collision semantics.
module tb_copmem_arbiter;

    localparam int unsigned AW = 10;
    localparam int unsigned SMAX = 4;

    logic          clk = 1'b0;
    logic          reset_n_i;
    logic          cop_rd_req_i;
    logic [AW-1:0] cop_rd_addr_i;
    logic          cop_rd_ack_o, cop_rd_valid_o;
    logic [31:0]   cop_rd_data_o;
    logic          host_rd_req_i;
    logic [AW:0]   host_rd_addr_i;
    logic          host_rd_ack_o, host_rd_valid_o;
    logic [15:0]   host_rd_data_o;
    logic          host_wr_req_i;
    logic [AW:0]   host_wr_addr_i;
    logic [15:0]   host_wr_data_i;
    logic          host_wr_ack_o;
    logic          even_rd_en_o, odd_rd_en_o;
    logic [AW-1:0] mem_rd_addr_o;
    logic [15:0]   even_rd_data_i, odd_rd_data_i;
    logic          even_wr_en_o, odd_wr_en_o;
    logic [AW-1:0] mem_wr_addr_o;
    logic [15:0]   mem_wr_data_o;

    copmem_arbiter #(.AWIDTH(AW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset_n_i(reset_n_i),
        .cop_rd_req_i(cop_rd_req_i), .cop_rd_addr_i(cop_rd_addr_i),
        .cop_rd_ack_o(cop_rd_ack_o), .cop_rd_valid_o(cop_rd_valid_o), .cop_rd_data_o(cop_rd_data_o),
        .host_rd_req_i(host_rd_req_i), .host_rd_addr_i(host_rd_addr_i),
        .host_rd_ack_o(host_rd_ack_o), .host_rd_valid_o(host_rd_valid_o), .host_rd_data_o(host_rd_data_o),
        .host_wr_req_i(host_wr_req_i), .host_wr_addr_i(host_wr_addr_i), .host_wr_data_i(host_wr_data_i),
        .host_wr_ack_o(host_wr_ack_o),
        .even_rd_en_o(even_rd_en_o), .odd_rd_en_o(odd_rd_en_o), .mem_rd_addr_o(mem_rd_addr_o),
        .even_rd_data_i(even_rd_data_i), .odd_rd_data_i(odd_rd_data_i),
        .even_wr_en_o(even_wr_en_o), .odd_wr_en_o(odd_wr_en_o),
        .mem_wr_addr_o(mem_wr_addr_o), .mem_wr_data_o(mem_wr_data_o)
    );

    always #5 clk = ~clk;

    // Bank models: synchronous read, old data on same-cycle write.
    logic [15:0] even_mem [0:(1<<AW)-1];
    logic [15:0] odd_mem  [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (even_rd_en_o) even_rd_data_i <= even_mem[mem_rd_addr_o];
        if (odd_rd_en_o)  odd_rd_data_i  <= odd_mem[mem_rd_addr_o];
        if (even_wr_en_o) even_mem[mem_wr_addr_o] <= mem_wr_data_o;
        if (odd_wr_en_o)  odd_mem[mem_wr_addr_o]  <= mem_wr_data_o;
    end

    // Reference model state
    logic [15:0]   sh_even [0:(1<<AW)-1];
    logic [15:0]   sh_odd  [0:(1<<AW)-1];
    int            s_kind [4];  // 0 none, 1 copper, 2 host; indexed by due cycle mod 4
    logic [31:0]   s_data [4];
    int unsigned   m_starve;
    logic [AW-1:0] m_last_addr;
    logic [31:0]   m_last_cop;
    logic [15:0]   m_last_host;
    int unsigned   cyc;
    logic          t_host_ack, t_cop_valid, t_host_valid;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            s_kind[i] = 0;
            s_data[i] = '0;
        end
        m_starve    = 0;
        m_last_addr = '0;
        m_last_cop  = '0;
        m_last_host = '0;
    endtask

    task automatic idle_inputs();
        cop_rd_req_i  = 1'b0;
        host_rd_req_i = 1'b0;
        host_wr_req_i = 1'b0;
    endtask

    // One clock cycle: check mid-cycle against the model, advance model, step clock.
    task automatic tick();
        bit cg, hg, ee, eo;
        logic [AW-1:0] ea;
        int slot;
        #4;
        cg = cop_rd_req_i && !(host_rd_req_i && m_starve == SMAX);
        hg = host_rd_req_i && !cg;
        ee = cg || (hg && !host_rd_addr_i[0]);
        eo = cg || (hg && host_rd_addr_i[0]);
        ea = cg ? cop_rd_addr_i : (hg ? host_rd_addr_i[AW:1] : m_last_addr);
        chk("cop_ack", cop_rd_ack_o, cg);
        chk("host_ack", host_rd_ack_o, hg);
        chk("even_rd_en", even_rd_en_o, ee);
        chk("odd_rd_en", odd_rd_en_o, eo);
        chk("mem_rd_addr", mem_rd_addr_o, ea);
        chk("wr_ack", host_wr_ack_o, host_wr_req_i);
        chk("even_wr_en", even_wr_en_o, host_wr_req_i && !host_wr_addr_i[0]);
        chk("odd_wr_en", odd_wr_en_o, host_wr_req_i && host_wr_addr_i[0]);
        if (host_wr_req_i) begin
            chk("wr_addr", mem_wr_addr_o, host_wr_addr_i[AW:1]);
            chk("wr_data", mem_wr_data_o, host_wr_data_i);
        end
        slot = int'(cyc % 4);
        if (s_kind[slot] == 1) m_last_cop = s_data[slot];
        if (s_kind[slot] == 2) m_last_host = s_data[slot][15:0];
        chk("cop_valid", cop_rd_valid_o, s_kind[slot] == 1);
        chk("host_valid", host_rd_valid_o, s_kind[slot] == 2);
        chk("cop_data", cop_rd_data_o, m_last_cop);
        chk("host_data", host_rd_data_o, m_last_host);
        s_kind[slot] = 0;
        t_host_ack   = host_rd_ack_o;
        t_cop_valid  = cop_rd_valid_o;
        t_host_valid = host_rd_valid_o;

        if (host_wr_req_i) begin
            if (host_wr_addr_i[0]) sh_odd[host_wr_addr_i[AW:1]] = host_wr_data_i;
            else                   sh_even[host_wr_addr_i[AW:1]] = host_wr_data_i;
        end
        slot = int'((cyc + 2) % 4);
        if (cg) begin
            s_kind[slot] = 1;
            s_data[slot] = {sh_even[cop_rd_addr_i], sh_odd[cop_rd_addr_i]};
        end else if (hg) begin
            s_kind[slot] = 2;
            s_data[slot] = {16'h0, host_rd_addr_i[0] ? sh_odd[host_rd_addr_i[AW:1]]
                                                     : sh_even[host_rd_addr_i[AW:1]]};
        end
        m_last_addr = ea;
        if (hg) m_starve = 0;
        else if (host_rd_req_i && m_starve < SMAX) m_starve++;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cop_ack"}, cop_rd_ack_o, 0);
        chk({tag, "_host_ack"}, host_rd_ack_o, 0);
        chk({tag, "_rd_en"}, {even_rd_en_o, odd_rd_en_o}, 0);
        chk({tag, "_wr_en"}, {even_wr_en_o, odd_wr_en_o, host_wr_ack_o}, 0);
        chk({tag, "_valid"}, {cop_rd_valid_o, host_rd_valid_o}, 0);
        chk({tag, "_cop_data"}, cop_rd_data_o, 0);
        chk({tag, "_host_data"}, host_rd_data_o, 0);
        chk({tag, "_rd_addr"}, mem_rd_addr_o, 0);
    endtask

    typedef struct {
        bit          is_host;
        logic [AW:0] addr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [5];
    int   nvalid;

    initial begin
        vecs[0] = '{1'b0, 11'd5,  32'h1234_ABCD};
        vecs[1] = '{1'b1, 11'd11, 32'h0000_ABCD};
        vecs[2] = '{1'b1, 11'd10, 32'h0000_1234};
        vecs[3] = '{1'b0, 11'd7,  32'h0000_7777};
        vecs[4] = '{1'b1, 11'd15, 32'h0000_7777};

        for (int i = 0; i < (1 << AW); i++) begin
            even_mem[i] = 16'($urandom);
            odd_mem[i]  = 16'($urandom);
        end
        even_mem[5] = 16'h1234;
        odd_mem[5]  = 16'hABCD;
        even_mem[7] = 16'h0000;
        odd_mem[7]  = 16'h7777;
        for (int i = 0; i < (1 << AW); i++) begin
            sh_even[i] = even_mem[i];
            sh_odd[i]  = odd_mem[i];
        end
        even_rd_data_i = '0;
        odd_rd_data_i  = '0;
        cop_rd_addr_i  = '0;
        host_rd_addr_i = '0;
        host_wr_addr_i = '0;
        host_wr_data_i = '0;
        cyc = 0;
        model_reset();

        // Reset state with requests asserted: combinational outputs must stay low.
        reset_n_i     = 1'b0;
        cop_rd_req_i  = 1'b1;
        host_rd_req_i = 1'b1;
        host_wr_req_i = 1'b1;
        @(posedge clk);
        #2;
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        idle_inputs();
        reset_n_i = 1'b1;

        // Directed single reads from the vector table.
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].is_host) begin
                host_rd_req_i  = 1'b1;
                host_rd_addr_i = vecs[i].addr;
            end else begin
                cop_rd_req_i  = 1'b1;
                cop_rd_addr_i = vecs[i].addr[AW-1:0];
            end
            tick();
            idle_inputs();
            tick();
            tick();
            if (vecs[i].is_host) chk("vec_host_data", host_rd_data_o, vecs[i].exp);
            else                 chk("vec_cop_data", cop_rd_data_o, vecs[i].exp);
        end

        // Write even[7] in the same cycle as a copper read of pair 7.
        cop_rd_req_i   = 1'b1;
        cop_rd_addr_i  = 10'd7;
        host_wr_req_i  = 1'b1;
        host_wr_addr_i = 11'd14;
        host_wr_data_i = 16'h5555;
        tick();
        idle_inputs();
        tick();
        tick();
        chk("hazard_fwd", cop_rd_data_o, 32'h5555_7777);
        cop_rd_req_i = 1'b1;
        tick();
        idle_inputs();
        tick();
        tick();
        chk("hazard_reread", cop_rd_data_o, 32'h5555_7777);

        // Both requesters held: 4 copper grants, then one host grant, repeating.
        cop_rd_req_i   = 1'b1;
        cop_rd_addr_i  = 10'd5;
        host_rd_req_i  = 1'b1;
        host_rd_addr_i = 11'd10;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("starve_host_ack", t_host_ack, (i == 4 || i == 9));
        end
        idle_inputs();
        tick();
        tick();

        // Alternating back-to-back grants: 8 consecutive valid strobes.
        nvalid = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                cop_rd_req_i   = (i % 2 == 0);
                host_rd_req_i  = (i % 2 == 1);
                cop_rd_addr_i  = 10'($urandom_range(0, 15));
                host_rd_addr_i = 11'($urandom_range(0, 31));
            end else begin
                idle_inputs();
            end
            tick();
            if (i >= 2) begin
                chk("alt_cop_strobe", t_cop_valid, (i % 2 == 0));
                chk("alt_host_strobe", t_host_valid, (i % 2 == 1));
            end
            nvalid += int'(t_cop_valid) + int'(t_host_valid);
        end
        chk("alt_strobe_count", nvalid, 8);

        // Reset mid-stream right after a copper grant: the read must be dropped.
        cop_rd_req_i  = 1'b1;
        cop_rd_addr_i = 10'd5;
        tick();
        reset_n_i     = 1'b0;
        host_rd_req_i = 1'b1;
        host_wr_req_i = 1'b1;
        #2;
        check_reset_outputs("mid");
        @(posedge clk);
        #1;
        check_reset_outputs("mid_hold");
        idle_inputs();
        reset_n_i = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) tick();

        // Random traffic over a narrow address window to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            cop_rd_req_i   = ($urandom_range(0, 3) != 0);
            host_rd_req_i  = ($urandom_range(0, 2) != 0);
            host_wr_req_i  = ($urandom_range(0, 1) != 0);
            cop_rd_addr_i  = 10'($urandom_range(0, 7));
            host_rd_addr_i = 11'($urandom_range(0, 15));
            host_wr_addr_i = 11'($urandom_range(0, 15));
            host_wr_data_i = 16'($urandom);
            tick();
        end
        idle_inputs();
        tick();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
